// File: rtl/isqrt_share_pkg.sv
`default_nettype none
// ============================================================================
// isqrt_share_pkg : operand type and round-robin pick helper shared by the
//                   isqrt sharing controller.
// Revision        : 1.0
// ============================================================================
package isqrt_share_pkg;
    localparam int ISQRT_W    = 32;
    localparam int c_MAX_REQ  = 8;
    localparam int c_MAX_ID_W = 3;

    typedef logic [ISQRT_W-1:0] operand_t;

    typedef struct packed {
        logic                  found;
        logic [c_MAX_ID_W-1:0] id;
    } rr_pick_t;

    // Walks offsets from high to low so the smallest offset from ptr wins.
    function automatic rr_pick_t rr_pick(input logic [c_MAX_REQ-1:0]  vld,
                                         input logic [c_MAX_ID_W-1:0] ptr,
                                         input int                    n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = c_MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = int'(ptr) + k;
                if (idx >= n) idx = idx - n;
                if (vld[idx]) begin
                    r.found = 1'b1;
                    r.id    = idx[c_MAX_ID_W-1:0];
                end
            end
        end
        return r;
    endfunction
endpackage
`default_nettype wire

// File: rtl/flip_flop_fifo_with_counter.sv
`default_nettype none
// ============================================================================
// flip_flop_fifo_with_counter : register-based FIFO with occupancy count;
//                               push and pop together are legal when full.
// Revision : 1.0
// ============================================================================
module flip_flop_fifo_with_counter #(
    parameter int width = 8,
    parameter int depth = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [width-1:0]             din,
    input  logic                         pop,
    output logic [width-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(depth+1)-1:0]   count
);
    localparam int c_PTR_W = (depth > 1) ? $clog2(depth) : 1;
    localparam int c_CNT_W = $clog2(depth + 1);

    logic [width-1:0]   r_mem [depth];
    logic [c_PTR_W-1:0] r_wr;
    logic [c_PTR_W-1:0] r_rd;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_push;
    logic               w_pop;

    assign empty  = (r_cnt == '0);
    assign full   = (r_cnt == c_CNT_W'(depth));
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || pop);
    assign dout   = r_mem[r_rd];
    assign count  = r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == c_PTR_W'(depth - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)  r_rd <= (r_rd == c_PTR_W'(depth - 1)) ? '0 : r_rd + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
endmodule
`default_nettype wire

// File: rtl/isqrt.sv
`default_nettype none
// ============================================================================
// isqrt : pipelined digit-by-digit integer square root, latency n_pipe_stages.
// Revision : 1.0
// ============================================================================
module isqrt
    import isqrt_share_pkg::*;
#(
    parameter int n_pipe_stages = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x_vld,
    input  operand_t             x,
    output logic                 y_vld,
    output logic [ISQRT_W/2-1:0] y
);
    localparam int c_RW    = ISQRT_W / 2;
    localparam int c_REM_W = c_RW + 4;
    localparam int c_IPS   = (c_RW + n_pipe_stages - 1) / n_pipe_stages;

    logic               r_vld  [n_pipe_stages];
    logic [c_REM_W-1:0] r_rem  [n_pipe_stages];
    logic [c_RW-1:0]    r_root [n_pipe_stages];
    operand_t           r_xs   [n_pipe_stages];

    for (genvar s = 0; s < n_pipe_stages; s++) begin : g_stage
        logic               w_in_vld;
        logic [c_REM_W-1:0] w_in_rem;
        logic [c_RW-1:0]    w_in_root;
        operand_t           w_in_xs;
        logic [c_REM_W-1:0] w_rem;
        logic [c_REM_W-1:0] w_trial;
        logic [c_RW-1:0]    w_root;
        operand_t           w_xs;

        if (s == 0) begin : g_first
            assign w_in_vld  = x_vld;
            assign w_in_rem  = '0;
            assign w_in_root = '0;
            assign w_in_xs   = x;
        end else begin : g_next
            assign w_in_vld  = r_vld[s-1];
            assign w_in_rem  = r_rem[s-1];
            assign w_in_root = r_root[s-1];
            assign w_in_xs   = r_xs[s-1];
        end

        // Each iteration brings down the next operand bit pair and tries root*4+1.
        always_comb begin
            w_rem   = w_in_rem;
            w_root  = w_in_root;
            w_xs    = w_in_xs;
            w_trial = '0;
            for (int j = 0; j < c_IPS; j++) begin
                if (s * c_IPS + j < c_RW) begin
                    w_rem   = {w_rem[c_REM_W-3:0], w_xs[ISQRT_W-1 -: 2]};
                    w_xs    = {w_xs[ISQRT_W-3:0], 2'b00};
                    w_trial = {2'b00, w_root, 2'b01};
                    if (w_rem >= w_trial) begin
                        w_rem  = w_rem - w_trial;
                        w_root = {w_root[c_RW-2:0], 1'b1};
                    end else begin
                        w_root = {w_root[c_RW-2:0], 1'b0};
                    end
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld[s]  <= 1'b0;
                r_rem[s]  <= '0;
                r_root[s] <= '0;
                r_xs[s]   <= '0;
            end else begin
                r_vld[s]  <= w_in_vld;
                r_rem[s]  <= w_rem;
                r_root[s] <= w_root;
                r_xs[s]   <= w_xs;
            end
        end
    end

    logic w_unused_tail;
    assign w_unused_tail = ^{r_rem[n_pipe_stages-1], r_xs[n_pipe_stages-1]};

    assign y_vld = r_vld[n_pipe_stages-1];
    assign y     = r_root[n_pipe_stages-1];
endmodule
`default_nettype wire

// File: rtl/isqrt_rr_share_ctrl.sv
`default_nettype none
// ============================================================================
// isqrt_rr_share_ctrl : round-robin sharing of one pipelined isqrt among
//                       N_REQ requesters, results routed back by tag.
// Revision : 1.0
// ============================================================================
module isqrt_rr_share_ctrl
    import isqrt_share_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int ISQRT_STAGES = 4,
    parameter int TAG_DEPTH    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_vld,
    input  logic [N_REQ*ISQRT_W-1:0]       req_x,
    output logic [N_REQ-1:0]               req_rdy,
    output logic [N_REQ-1:0]               res_vld,
    output logic [ISQRT_W-1:0]             res,
    output logic [$clog2(TAG_DEPTH+1)-1:0] in_flight
);
    localparam int ID_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] c_ONE = N_REQ'(1);

    logic                 w_rst_core;
    rr_pick_t             w_pick;
    logic [ID_W-1:0]      w_gid;
    logic                 w_issue;
    operand_t             w_x;
    logic                 w_y_vld;
    logic [ISQRT_W/2-1:0] w_y;
    logic [ID_W-1:0]      w_tag;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_unused_id;
    logic [ID_W-1:0]      r_ptr;

    assign w_rst_core  = ~rst;
    assign w_pick      = rr_pick(c_MAX_REQ'(req_vld), c_MAX_ID_W'(r_ptr), N_REQ);
    assign w_gid       = w_pick.id[ID_W-1:0];
    assign w_unused_id = ^w_pick.id;

    // A full tag FIFO still takes a push when a result pops in the same cycle.
    assign w_issue = rst && w_pick.found && !(w_full && !w_y_vld);
    assign w_x     = req_x[w_gid*ISQRT_W +: ISQRT_W];
    assign req_rdy = w_issue ? (c_ONE << w_gid) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            r_ptr <= (w_gid == ID_W'(N_REQ - 1)) ? '0 : w_gid + 1'b1;
        end
    end

    isqrt #(
        .n_pipe_stages(ISQRT_STAGES)
    ) u_isqrt (
        .clk  (clk),
        .rst  (w_rst_core),
        .x_vld(w_issue),
        .x    (w_x),
        .y_vld(w_y_vld),
        .y    (w_y)
    );

    flip_flop_fifo_with_counter #(
        .width(ID_W),
        .depth(TAG_DEPTH)
    ) u_tag_fifo (
        .clk  (clk),
        .rst  (w_rst_core),
        .push (w_issue),
        .din  (w_gid),
        .pop  (w_y_vld),
        .dout (w_tag),
        .empty(w_empty),
        .full (w_full),
        .count(in_flight)
    );

    assign res     = {{(ISQRT_W/2){1'b0}}, w_y};
    assign res_vld = (rst && w_y_vld && !w_empty) ? (c_ONE << w_tag) : '0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst) begin
            a_tag_room: assert (!(w_pick.found && w_full && !w_y_vld))
                else $error("tag FIFO full: TAG_DEPTH below isqrt latency");
            a_tag_present: assert (!(w_y_vld && w_empty))
                else $error("isqrt result with empty tag FIFO");
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_isqrt_rr_share_ctrl.sv
`default_nettype none
// ============================================================================
// tb_isqrt_rr_share_ctrl : directed and random bench with a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_isqrt_rr_share_ctrl;
    localparam int N     = 4;
    localparam int LAT   = 4;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_vld = '0;
    logic [N*32-1:0] req_x = '0;
    logic [N-1:0]    req_rdy;
    logic [N-1:0]    res_vld;
    logic [31:0]     res;
    logic [CW-1:0]   in_flight;

    always #5 clk = ~clk;

    isqrt_rr_share_ctrl #(
        .N_REQ(N), .ISQRT_STAGES(LAT), .TAG_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_x(req_x),
        .req_rdy(req_rdy), .res_vld(res_vld), .res(res), .in_flight(in_flight)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned ref_sqrt(input longint unsigned x);
        longint unsigned s;
        s = longint'($floor($sqrt(real'(x))));
        while (s * s > x) s--;
        while ((s + 1) * (s + 1) <= x) s++;
        return s;
    endfunction

    typedef struct { int id; longint unsigned root; int due; } pend_t;
    typedef struct { int id; longint unsigned val; int cyc; } ev_t;

    pend_t pend[$];
    ev_t   gnt_log[$];
    ev_t   res_log[$];
    int    cyc = 0;
    int    m_ptr = 0;
    bit    mon_on = 1'b0;
    int    act_iss = 0;
    int    act_ret = 0;

    // Model: round-robin from m_ptr, each issue returns exactly LAT cycles later in order.
    always @(negedge clk) begin : p_cmp
        logic [N-1:0] e_rdy;
        logic [N-1:0] e_vld;
        int           w;
        int           idx;
        pend_t        p;
        ev_t          ev;
        if (mon_on) begin
            if (!rst) begin
                chk("rst_req_rdy", req_rdy, 0);
                chk("rst_res_vld", res_vld, 0);
                chk("rst_res", res, 0);
                chk("rst_in_flight", in_flight, 0);
                pend.delete();
                m_ptr = 0;
            end else begin
                chk("in_flight", in_flight, pend.size());
                w = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && req_vld[idx]) w = idx;
                end
                e_rdy = '0;
                if (w >= 0) e_rdy[w] = 1'b1;
                chk("req_rdy", req_rdy, e_rdy);
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    p = pend.pop_front();
                    e_vld = '0;
                    e_vld[p.id] = 1'b1;
                    chk("res_vld", res_vld, e_vld);
                    chk("res", res, p.root);
                end else begin
                    chk("res_vld_idle", res_vld, 0);
                end
                if (w >= 0) begin
                    p.id = w; p.root = ref_sqrt(longint'(req_x[w*32 +: 32])); p.due = cyc + LAT;
                    pend.push_back(p);
                    m_ptr = (w + 1) % N;
                end
                for (int k = 0; k < N; k++) begin
                    if (req_rdy[k]) begin
                        ev.id = k; ev.val = longint'(req_x[k*32 +: 32]); ev.cyc = cyc;
                        gnt_log.push_back(ev);
                        if (req_vld[k]) act_iss++;
                    end
                    if (res_vld[k]) begin
                        ev.id = k; ev.val = longint'(res); ev.cyc = cyc;
                        res_log.push_back(ev);
                        act_ret++;
                    end
                end
            end
            cyc++;
        end
    end

    int unsigned src_q [N][$];
    int          last_inflight = 0;

    task automatic present();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_vld[i] = 1'b1;
                req_x[i*32 +: 32] = src_q[i][0];
            end else begin
                req_vld[i] = 1'b0;
                req_x[i*32 +: 32] = '0;
            end
        end
    endtask

    // Called just after a posedge; returns just after the next posedge.
    task automatic cycle();
        logic [N-1:0] taken;
        @(negedge clk);
        taken = req_vld & req_rdy;
        last_inflight = int'(in_flight);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (taken[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        present();
    endtask

    function automatic bit busy();
        bit b = 1'b0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string name);
        int k = 0;
        while ((busy() || pend.size() > 0) && k < 300) begin
            cycle();
            k++;
        end
        chk({name, "_drained"}, pend.size() + int'(busy()), 0);
        repeat (LAT + 2) cycle();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        res_log.delete();
    endtask

    longint unsigned exp1 [5] = '{0, 1, 3, 4, 65535};
    int              exp3 [6] = '{3, 1, 3, 1, 3, 1};
    int unsigned     thr  [N] = '{9, 5, 2, 7};

    initial begin
        #1 rst = 1'b0;
        mon_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        chk("ref_sqrt_max", ref_sqrt(64'hFFFF_FFFF), 65535);
        chk("ref_sqrt_15", ref_sqrt(15), 3);

        // 1: one requester, edge operands back-to-back
        clear_logs();
        src_q[0] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'hFFFF_FFFF};
        present();
        drain("t1");
        chk("t1_res_count", res_log.size(), 5);
        for (int i = 0; i < 5 && i < res_log.size() && i < gnt_log.size(); i++) begin
            chk("t1_res_id", res_log[i].id, 0);
            chk("t1_res_val", res_log[i].val, exp1[i]);
            chk("t1_latency", res_log[i].cyc - gnt_log[i].cyc, 4);
        end

        // 2/5: all four requesting from reset, pipeline run at full rate
        do_reset(2);
        clear_logs();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 6; k++) src_q[i].push_back((i + 1) * 40503 * (k + 3));
        present();
        repeat (6) cycle();
        chk("t2_inflight_full", last_inflight, 4);
        drain("t2");
        chk("t2_grant_count", gnt_log.size(), 24);
        chk("t2_res_count", res_log.size(), 24);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("t2_grant_order", gnt_log[i].id, i % 4);

        // 3: only 1 and 3 valid with ptr at 2
        src_q[1].push_back(4);
        present();
        drain("t3_setup");
        clear_logs();
        src_q[1] = '{32'd81, 32'd121, 32'd144};
        src_q[3] = '{32'd169, 32'd196, 32'd225};
        present();
        drain("t3");
        chk("t3_grant_count", gnt_log.size(), 6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) chk("t3_grant_order", gnt_log[i].id, exp3[i]);
        if (res_log.size() > 0) chk("t3_first_root", res_log[0].val, 13);

        // 4: reset with three operands in flight and one requester still waiting
        clear_logs();
        src_q[0] = '{32'd9, 32'd25, 32'd49};
        present();
        repeat (3) cycle();
        src_q[1].push_back(36);
        present();
        do_reset(2);
        chk("t4_no_leak", res_log.size(), 0);
        src_q[2].push_back(100);
        present();
        drain("t4");
        chk("t4_res_count", res_log.size(), 2);
        if (res_log.size() == 2) begin
            chk("t4_first_id", res_log[0].id, 1);
            chk("t4_first_val", res_log[0].val, 6);
            chk("t4_second_id", res_log[1].id, 2);
            chk("t4_second_val", res_log[1].val, 10);
        end

        // 6: random valid patterns
        act_iss = 0;
        act_ret = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() == 0 && $urandom_range(0, 9) < thr[i]) begin
                    case ($urandom_range(0, 7))
                        0: src_q[i].push_back(32'd0);
                        1: src_q[i].push_back(32'hFFFF_FFFF);
                        2: begin
                            int unsigned r = $urandom_range(1, 65535);
                            src_q[i].push_back(r * r - 1);
                        end
                        default: src_q[i].push_back($urandom);
                    endcase
                end
            end
            present();
            cycle();
        end
        drain("t6");
        chk("t6_issued_eq_returned", act_ret, act_iss);
        chk("t6_final_in_flight", in_flight, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
